// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the exhaustive sweep engine
package sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } sweep_state_t;

    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
    localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/sweep_misr.sv
// rtl/sweep_misr.sv - single-input MISR compacting one response bit per shift
// Ports:
//   CK        in   clock
//   reset     in   asynchronous active-high reset, loads SEED
//   load      in   reload SEED (has priority over shift_en)
//   shift_en  in   shift in data_in this cycle
//   data_in   in   serial response bit
//   signature out  current MISR value
module sweep_misr #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   POLY  = 16'h1021,
    parameter logic [WIDTH-1:0]   SEED  = 16'hFFFF
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] signature
);

    logic [WIDTH-1:0] sig_next;

    // Galois-style step: feedback taps applied when the outgoing MSB is set,
    // response bit folded into bit 0.
    always_comb begin
        sig_next = {signature[WIDTH-2:0], 1'b0};
        if (signature[WIDTH-1]) begin
            sig_next = sig_next ^ POLY;
        end
        sig_next[0] = sig_next[0] ^ data_in;
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            signature <= SEED;
        end else if (load) begin
            signature <= SEED;
        end else if (shift_en) begin
            signature <= sig_next;
        end
    end

endmodule

// File: rtl/exhaustive_sweep_engine.sv
// rtl/exhaustive_sweep_engine.sv - exhaustive input sweep with response capture and MISR
// Ports:
//   CK           in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   begin a sweep (honoured in IDLE or DONE only)
//   N            out  pattern driven to the unit under test
//   dut_out      in   response of the unit under test
//   rec_valid    out  record available to the logger
//   rec_ready    in   logger accepts record
//   rec_pattern  out  pattern of the current record
//   rec_resp     out  sampled response of the current record
//   busy         out  high while settling or emitting
//   done         out  high once the sweep has finished, until next start/reset
//   signature    out  current MISR value
module exhaustive_sweep_engine
    import sweep_pkg::*;
#(
    parameter int                     N_WIDTH       = 5,
    parameter int                     SETTLE_CYCLES = 1,
    parameter int                     SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0]   SIG_POLY      = DEF_SIG_POLY,
    parameter logic [SIG_WIDTH-1:0]   SIG_SEED      = DEF_SIG_SEED
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_WIDTH-1:0]   N,
    input  logic                 dut_out,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_pattern,
    output logic                 rec_resp,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature
);

    localparam logic [7:0]         CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_WIDTH-1:0] N_LAST     = '1;

    sweep_state_t state;
    logic [7:0]   settle_cnt;
    logic         start_ok;
    logic         capture;

    // Start is only accepted from a quiescent state; the MISR reseeds on the
    // same edge the FSM enters SETTLE.
    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign capture  = (state == S_SETTLE) && (settle_cnt == 8'd0);

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            N           <= '0;
            settle_cnt  <= '0;
            rec_valid   <= 1'b0;
            rec_pattern <= '0;
            rec_resp    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        N          <= '0;
                        settle_cnt <= CNT_RELOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        rec_resp    <= dut_out;
                        rec_pattern <= N;
                        rec_valid   <= 1'b1;
                        state       <= S_EMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        // Terminate on the all-ones compare so N never wraps.
                        if (N == N_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            N          <= N + 1'b1;
                            settle_cnt <= CNT_RELOAD;
                            state      <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    sweep_misr #(
        .WIDTH (SIG_WIDTH),
        .POLY  (SIG_POLY),
        .SEED  (SIG_SEED)
    ) u_misr (
        .CK        (CK),
        .reset     (reset),
        .load      (start_ok),
        .shift_en  (capture),
        .data_in   (dut_out),
        .signature (signature)
    );

endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// tb/tb_exhaustive_sweep_engine.sv - table-driven bench for exhaustive_sweep_engine
module tb_exhaustive_sweep_engine;

    typedef struct {
        int          mode;       // response function selector
        int          stall_pat;  // pattern on which rec_ready drops for 10 cycles (-1 none)
        int          start_pat;  // pattern on which a stray start is pulsed (-1 none)
        int          abort_pat;  // pattern in EMIT on which reset is asserted (-1 none)
        logic [15:0] exp_sig;    // expected final signature (seed 0)
    } vec_t;

    logic        CK = 1'b0;
    always #5 CK = ~CK;

    // Instance A: default timing, seed 0.
    logic        rst_a, start_a, rec_ready_a, dut_out_a;
    logic [4:0]  N_a, rec_pattern_a;
    logic        rec_valid_a, rec_resp_a, busy_a, done_a;
    logic [15:0] sig_a;
    int          mode_a;

    // Instance B: three settle cycles, default seed.
    logic        rst_b, start_b, rec_ready_b, dut_out_b;
    logic [4:0]  N_b, rec_pattern_b;
    logic        rec_valid_b, rec_resp_b, busy_b, done_b;
    logic [15:0] sig_b;

    int nvec  = 0;
    int nfail = 0;

    function automatic logic resp_of(input int mode, input logic [4:0] pat);
        case (mode)
            1:       return pat == 5'd31;
            2:       return pat >= 5'd30;
            3:       return pat == 5'd15;
            4:       return pat == 5'd16;
            5:       return pat == 5'd14;
            6:       return pat == 5'd3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] misr_model(input logic [15:0] seed, input int nzeros);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < nzeros; i++) begin
            s = s[15] ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
        end
        return s;
    endfunction

    assign dut_out_a = resp_of(mode_a, N_a);

    exhaustive_sweep_engine #(
        .N_WIDTH(5), .SETTLE_CYCLES(1), .SIG_WIDTH(16),
        .SIG_POLY(16'h1021), .SIG_SEED(16'h0000)
    ) dut_a (
        .CK(CK), .reset(rst_a), .start(start_a), .N(N_a), .dut_out(dut_out_a),
        .rec_valid(rec_valid_a), .rec_ready(rec_ready_a), .rec_pattern(rec_pattern_a),
        .rec_resp(rec_resp_a), .busy(busy_a), .done(done_a), .signature(sig_a)
    );

    exhaustive_sweep_engine #(
        .N_WIDTH(5), .SETTLE_CYCLES(3), .SIG_WIDTH(16),
        .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
    ) dut_b (
        .CK(CK), .reset(rst_b), .start(start_b), .N(N_b), .dut_out(dut_out_b),
        .rec_valid(rec_valid_b), .rec_ready(rec_ready_b), .rec_pattern(rec_pattern_b),
        .rec_resp(rec_resp_b), .busy(busy_b), .done(done_b), .signature(sig_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_a(input vec_t v, input int idx);
        int          last_edge;
        int          n_rec;
        int          exp_edge;
        bit          stalled;
        bit          pulsed;
        bit          hold_ok;
        logic [15:0] sig_hold;
        mode_a      = v.mode;
        rec_ready_a = 1'b1;
        @(negedge CK);
        start_a = 1'b1;
        @(posedge CK);
        last_edge = 0;
        #1;
        start_a = 1'b0;
        chk($sformatf("v%0d start_state", idx), {27'd0, N_a, busy_a, done_a}, 32'h2);
        n_rec   = 0;
        stalled = 0;
        pulsed  = 0;
        while (last_edge < 400) begin
            @(negedge CK);
            start_a = 1'b0;
            if (v.start_pat >= 0 && !pulsed && busy_a && N_a == 5'(v.start_pat)) begin
                start_a = 1'b1;
                pulsed  = 1;
            end
            if (v.stall_pat >= 0 && !stalled && rec_valid_a && rec_pattern_a == 5'(v.stall_pat)) begin
                stalled     = 1;
                rec_ready_a = 1'b0;
                sig_hold    = sig_a;
                hold_ok     = 1;
                repeat (10) begin
                    @(posedge CK);
                    last_edge++;
                    @(negedge CK);
                    if (!(rec_valid_a && rec_pattern_a == 5'(v.stall_pat) &&
                          N_a == 5'(v.stall_pat) && sig_a == sig_hold))
                        hold_ok = 0;
                end
                chk($sformatf("v%0d stall_hold", idx), 32'(hold_ok), 32'd1);
                rec_ready_a = 1'b1;
            end
            if (v.abort_pat >= 0 && rec_valid_a && rec_pattern_a == 5'(v.abort_pat)) begin
                chk($sformatf("v%0d pre_abort_sig_nonzero", idx), 32'(sig_a != 16'h0), 32'd1);
                rst_a = 1'b1;
                #1;
                chk($sformatf("v%0d abort_outputs", idx),
                    {2'd0, N_a, rec_valid_a, rec_pattern_a, rec_resp_a, busy_a, done_a, sig_a}, 32'd0);
                @(negedge CK);
                rst_a = 1'b0;
                repeat (5) @(negedge CK);
                chk($sformatf("v%0d abort_stays_idle", idx),
                    {25'd0, N_a, rec_valid_a, busy_a}, 32'd0);
                return;
            end
            if (rec_valid_a && rec_ready_a) begin
                chk($sformatf("v%0d rec%0d pattern", idx, n_rec), 32'(rec_pattern_a), 32'(n_rec));
                chk($sformatf("v%0d rec%0d resp", idx, n_rec), 32'(rec_resp_a),
                    32'(resp_of(v.mode, 5'(n_rec))));
                n_rec++;
            end
            if (done_a) break;
            @(posedge CK);
            last_edge++;
        end
        start_a  = 1'b0;
        exp_edge = (v.stall_pat >= 0) ? 74 : 64;
        chk($sformatf("v%0d rec_count", idx), 32'(n_rec), 32'd32);
        chk($sformatf("v%0d done_edge", idx), 32'(last_edge), 32'(exp_edge));
        chk($sformatf("v%0d end_flags", idx), {30'd0, busy_a, done_a}, 32'd1);
        chk($sformatf("v%0d signature", idx), 32'(sig_a), 32'(v.exp_sig));
    endtask

    task automatic run_b();
        int         last_edge;
        int         n_rec;
        int         k;
        logic [4:0] prev_n;
        rec_ready_b = 1'b1;
        @(negedge CK);
        start_b = 1'b1;
        @(posedge CK);
        last_edge = 0;
        #1;
        start_b   = 1'b0;
        prev_n    = N_b;
        k         = 1;
        dut_out_b = 1'b1;
        n_rec     = 0;
        while (last_edge < 400) begin
            @(posedge CK);
            last_edge++;
            #1;
            if (N_b != prev_n) begin
                k      = 1;
                prev_n = N_b;
            end else begin
                k++;
            end
            // High only in the first two cycles after each pattern change.
            dut_out_b = (k == 1 || k == 2) && busy_b;
            if (rec_valid_b && rec_ready_b) begin
                chk($sformatf("b rec%0d pattern", n_rec), 32'(rec_pattern_b), 32'(n_rec));
                chk($sformatf("b rec%0d resp", n_rec), 32'(rec_resp_b), 32'd0);
                n_rec++;
            end
            if (done_b) break;
        end
        dut_out_b = 1'b0;
        chk("b rec_count", 32'(n_rec), 32'd32);
        chk("b done_edge", 32'(last_edge), 32'd128);
        chk("b signature", 32'(sig_b), 32'(misr_model(16'hFFFF, 32)));
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{mode: 0, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h0000};
        tbl[1] = '{mode: 1, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h0001};
        tbl[2] = '{mode: 2, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h0003};
        tbl[3] = '{mode: 3, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h1021};
        tbl[4] = '{mode: 4, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h8000};
        tbl[5] = '{mode: 5, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h2042};
        tbl[6] = '{mode: 0, stall_pat:  7, start_pat: -1, abort_pat: -1, exp_sig: 16'h0000};
        tbl[7] = '{mode: 2, stall_pat: -1, start_pat:  4, abort_pat: -1, exp_sig: 16'h0003};
        tbl[8] = '{mode: 6, stall_pat: -1, start_pat: -1, abort_pat: 12, exp_sig: 16'h0000};
        tbl[9] = '{mode: 1, stall_pat: -1, start_pat: -1, abort_pat: -1, exp_sig: 16'h0001};

        rst_a = 1'b1; start_a = 1'b0; rec_ready_a = 1'b1; mode_a = 0;
        rst_b = 1'b1; start_b = 1'b0; rec_ready_b = 1'b1; dut_out_b = 1'b0;
        repeat (2) @(negedge CK);
        chk("a reset_values",
            {2'd0, N_a, rec_valid_a, rec_pattern_a, rec_resp_a, busy_a, done_a, sig_a}, 32'd0);
        chk("b reset_signature", 32'(sig_b), 32'h0000FFFF);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge CK);
        chk("a idle_after_release", {25'd0, N_a, rec_valid_a, busy_a}, 32'd0);

        // Start coincident with reset: reset must win.
        @(negedge CK);
        rst_a   = 1'b1;
        start_a = 1'b1;
        @(posedge CK);
        #1;
        start_a = 1'b0;
        @(negedge CK);
        rst_a = 1'b0;
        repeat (3) @(negedge CK);
        chk("a start_with_reset_ignored", {30'd0, busy_a, done_a}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_a(tbl[i], i);
        end

        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
